frame_check_ctrl: RTL

Session controller for the receive-side frame checker in the `clk125m` domain. It arms a check run on command and clears the checker. It aligns the run to a frame boundary seen on the receive FIFO write stream, and forwards exactly the requested number of whole frames to the checker. It then latches the checker's error count and reports pass/fail, with an optional no-traffic watchdog.

---
 rtl/frame_check_ctrl_if.sv | 31 +++
 rtl/frame_check_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/frame_check_ctrl_if.sv
// Bus bundle for frame_check_ctrl: command/status, receive stream and checker side.
// The master drives commands and the stream; the slave is the controller.
interface frame_check_ctrl_if;
    logic        start;
    logic        abort;
    logic [7:0]  frame_num;
    logic        fifo_wr_en;
    logic [28:0] din;
    logic [15:0] err_in;
    logic        chk_reset;
    logic        chk_wr_en;
    logic [28:0] chk_din;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] result_err;
    logic [7:0]  frames_done;

    modport master (
        output start, abort, frame_num, fifo_wr_en, din, err_in,
        input  chk_reset, chk_wr_en, chk_din, busy, done, pass,
        input  timeout, result_err, frames_done
    );

    modport slave (
        input  start, abort, frame_num, fifo_wr_en, din, err_in,
        output chk_reset, chk_wr_en, chk_din, busy, done, pass,
        output timeout, result_err, frames_done
    );
endinterface

// File: rtl/frame_check_ctrl.sv
// Frame checker session controller: clear, frame-aligned forwarding, drain, verdict.
// Optional no-traffic watchdog enabled by defining FRAME_CHECK_CTRL_TIMEOUT_EN.
module frame_check_ctrl #(
    parameter int unsigned CLR_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [23:0] TIMEOUT      = 24'd12_500_000
) (
    input logic               clk125m,
    input logic               reset,
    frame_check_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SYNC, RUN, DRAIN, DONE
    } state_t;

    localparam logic [3:0] CLR_LOAD   = 4'(CLR_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  frame_num_q;
    logic [10:0] prev_y;
    logic [10:0] y;
    logic        boundary;
    logic        last_frame;
    logic        idle_hit;

    always_comb begin
        y          = bus.din[26:16];
        boundary   = bus.fifo_wr_en && (y < prev_y);
        last_frame = (frame_num_q != 8'd0) &&
                     ((bus.frames_done + 8'd1) == frame_num_q);
    end

`ifdef FRAME_CHECK_CTRL_TIMEOUT_EN
    logic [23:0] idle_cnt;
    logic        watching;

    assign watching = (state == SYNC) || (state == RUN);
    assign idle_hit = watching && !bus.fifo_wr_en &&
                      (idle_cnt == TIMEOUT - 24'd1);

    always_ff @(posedge clk125m) begin
        if (reset || !watching || bus.fifo_wr_en) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    always_ff @(posedge clk125m) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            frame_num_q     <= '0;
            prev_y          <= '0;
            bus.chk_reset   <= 1'b0;
            bus.chk_wr_en   <= 1'b0;
            bus.chk_din     <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.result_err  <= '0;
            bus.frames_done <= '0;
        end else begin
            bus.chk_din   <= bus.din;
            bus.chk_wr_en <= 1'b0;
            if (bus.fifo_wr_en) begin
                prev_y <= y;
            end
            if (bus.abort) begin
                state         <= IDLE;
                bus.chk_reset <= 1'b0;
                bus.busy      <= 1'b0;
                bus.done      <= 1'b0;
                bus.pass      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            frame_num_q     <= bus.frame_num;
                            bus.frames_done <= '0;
                            bus.timeout     <= 1'b0;
                            bus.done        <= 1'b0;
                            bus.pass        <= 1'b0;
                            bus.busy        <= 1'b1;
                            bus.chk_reset   <= 1'b1;
                            cnt             <= CLR_LOAD;
                            state           <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (cnt == 4'd0) begin
                            bus.chk_reset <= 1'b0;
                            state         <= SYNC;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    SYNC: begin
                        if (idle_hit) begin
                            bus.timeout <= 1'b1;
                            cnt         <= DRAIN_LOAD;
                            state       <= DRAIN;
                        end else if (boundary) begin
                            bus.chk_wr_en <= 1'b1;
                            state         <= RUN;
                        end
                    end
                    RUN: begin
                        if (idle_hit) begin
                            bus.timeout <= 1'b1;
                            cnt         <= DRAIN_LOAD;
                            state       <= DRAIN;
                        end else if (boundary) begin
                            // saturates so continuous mode never wraps
                            if (bus.frames_done != 8'hff) begin
                                bus.frames_done <= bus.frames_done + 8'd1;
                            end
                            if (last_frame) begin
                                cnt   <= DRAIN_LOAD;
                                state <= DRAIN;
                            end else begin
                                bus.chk_wr_en <= 1'b1;
                            end
                        end else if (bus.fifo_wr_en) begin
                            bus.chk_wr_en <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (cnt == 4'd0) begin
                            bus.result_err <= bus.err_in;
                            bus.pass       <= (bus.err_in == 16'd0) &&
                                              !bus.timeout;
                            bus.done       <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= DONE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
